// File: rtl/statefull_arb.sv
// Round-robin scheduler sharing one statefull match/state stage among NUM_REQ requesters.
// Define STATEFULL_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module statefull_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 512,
  parameter int MIN_GAP   = 1,
  parameter int TAG_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_vld,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_rdy,
  output logic                        pkt_vld_in,
  output logic [DATA_W-1:0]           pkt_data_in,
  input  logic                        pkt_vld_out,
  input  logic [DATA_W-1:0]           pkt_data_out,
  input  logic [15:0]                 action_out,
  input  logic [7:0]                  state_out,
  output logic [NUM_REQ-1:0]          rsp_vld,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [15:0]                 rsp_action,
  output logic [7:0]                  rsp_state,
  output logic                        err_orphan
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam logic [2:0] GAP_LOAD = 3'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  typedef enum logic {IDLE, GAP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      gap_cnt, gap_nxt;
  logic [IW-1:0]   rr_ptr, base, win;
  logic            found, grant, full, pop, orphan;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [IW-1:0]   tag_mem [TAG_DEPTH];
  int              idx;

`ifdef STATEFULL_ARB_STRICT_PRIO_EN
  assign base = '0;
`else
  assign base = rr_ptr;
`endif

  assign full   = (cnt == CW'(TAG_DEPTH));
  assign pop    = pkt_vld_out && (cnt != '0);
  assign orphan = pkt_vld_out && (cnt == '0);

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    grant     = 1'b0;
    req_rdy   = '0;
    case (state)
      IDLE: begin
        if (found && !full) begin
          grant        = 1'b1;
          req_rdy[win] = 1'b1;
          if (MIN_GAP > 0) begin
            state_nxt = GAP;
            gap_nxt   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 3'd0) state_nxt = IDLE;
        else                 gap_nxt   = gap_cnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag storage needs no reset: occupancy is governed by cnt and the pointers.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_vld_in  <= 1'b0;
      pkt_data_in <= '0;
      rsp_vld     <= '0;
      rsp_data    <= '0;
      rsp_action  <= '0;
      rsp_state   <= '0;
      err_orphan  <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      pkt_vld_in <= grant;
      rsp_vld    <= '0;
      err_orphan <= err_orphan | orphan;
      if (grant) begin
        pkt_data_in <= req_data[win*DATA_W +: DATA_W];
        wr_ptr      <= (wr_ptr == AW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
`ifndef STATEFULL_ARB_STRICT_PRIO_EN
        rr_ptr      <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
      end
      if (pop) begin
        rsp_vld[tag_mem[rd_ptr]] <= 1'b1;
        rsp_data   <= pkt_data_out;
        rsp_action <= action_out;
        rsp_state  <= state_out;
        rd_ptr     <= (rd_ptr == AW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({grant, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_statefull_arb.sv
// Directed self-checking bench for statefull_arb with default parameters.
module tb_statefull_arb;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 512;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      pkt_vld_in;
  logic [DATA_W-1:0]         pkt_data_in;
  logic                      pkt_vld_out;
  logic [DATA_W-1:0]         pkt_data_out;
  logic [15:0]               action_out;
  logic [7:0]                state_out;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic [DATA_W-1:0]         rsp_data;
  logic [15:0]               rsp_action;
  logic [7:0]                rsp_state;
  logic                      err_orphan;

  int n_assert = 0;
  int n_fail   = 0;

  statefull_arb dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .pkt_vld_in(pkt_vld_in), .pkt_data_in(pkt_data_in), .pkt_vld_out(pkt_vld_out),
    .pkt_data_out(pkt_data_out), .action_out(action_out), .state_out(state_out),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_action(rsp_action), .rsp_state(rsp_state),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_vld     = '0;
    pkt_vld_out = 1'b0;
    reset       = 1'b1;
    #3;
    chk("rst_req_rdy", DATA_W'(req_rdy), '0);
    chk("rst_pkt_vld_in", DATA_W'(pkt_vld_in), '0);
    chk("rst_pkt_data_in", pkt_data_in, '0);
    chk("rst_rsp_vld", DATA_W'(rsp_vld), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_action", DATA_W'(rsp_action), '0);
    chk("rst_rsp_state", DATA_W'(rsp_state), '0);
    chk("rst_err_orphan", DATA_W'(err_orphan), '0);
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  initial begin
    logic [NUM_REQ-1:0] e_rdy;
    reset        = 1'b1;
    req_vld      = '0;
    req_data     = '0;
    pkt_vld_out  = 1'b0;
    pkt_data_out = '0;
    action_out   = '0;
    state_out    = '0;
    #2;

    // single requester 0
    do_reset();
    req_vld = 4'b0001;
    req_data[0 +: DATA_W] = DATA_W'('h4321);
    #1 chk("t1_rdy_grant", DATA_W'(req_rdy), DATA_W'(4'b0001));
    tick();
    req_vld = '0;
    #1 chk("t1_pkt_vld_in", DATA_W'(pkt_vld_in), DATA_W'(1));
    chk("t1_pkt_data_in", pkt_data_in, DATA_W'('h4321));
    chk("t1_rdy_after", DATA_W'(req_rdy), '0);
    tick();
    pkt_vld_out = 1'b1; pkt_data_out = DATA_W'('hBEEF); action_out = 16'h1234; state_out = 8'h5A;
    #1 chk("t1_pkt_vld_in_low", DATA_W'(pkt_vld_in), '0);
    chk("t1_rsp_vld_early", DATA_W'(rsp_vld), '0);
    tick();
    pkt_vld_out = 1'b0;
    #1 chk("t1_rsp_vld", DATA_W'(rsp_vld), DATA_W'(4'b0001));
    chk("t1_rsp_data", rsp_data, DATA_W'('hBEEF));
    chk("t1_rsp_action", DATA_W'(rsp_action), DATA_W'('h1234));
    chk("t1_rsp_state", DATA_W'(rsp_state), DATA_W'('h5A));
    tick();
    #1 chk("t1_rsp_vld_low", DATA_W'(rsp_vld), '0);
    chk("t1_rsp_data_hold", rsp_data, DATA_W'('hBEEF));
    chk("t1_pkt_data_hold", pkt_data_in, DATA_W'('h4321));

    // all requesters valid; returns on even cycles overlap the next grant
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'('hA0 + i);
    req_vld = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      pkt_vld_out  = (k % 2 == 0) && (k >= 2);
      pkt_data_out = DATA_W'('h100 + k);
      #1;
      chk($sformatf("t2_rdy_k%0d", k), DATA_W'(req_rdy),
          (k % 2 == 0) ? DATA_W'(oh((k / 2) % NUM_REQ)) : '0);
      chk($sformatf("t2_vld_in_k%0d", k), DATA_W'(pkt_vld_in), DATA_W'(k % 2));
      if (k % 2 == 1)
        chk($sformatf("t2_data_in_k%0d", k), pkt_data_in, DATA_W'('hA0 + ((k - 1) / 2) % NUM_REQ));
      chk($sformatf("t2_rsp_k%0d", k), DATA_W'(rsp_vld),
          (k % 2 == 1 && k >= 3) ? DATA_W'(oh(((k - 3) / 2) % NUM_REQ)) : '0);
      tick();
    end

    // stalled stage: tag FIFO fills after 4 grants
    do_reset();
    req_vld = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      pkt_vld_out  = (k == 10);
      pkt_data_out = DATA_W'('h77);
      #1;
      if (k < 8 && k % 2 == 0) e_rdy = oh(k / 2);
      else if (k == 11)        e_rdy = 4'b0001;
      else                     e_rdy = '0;
      chk($sformatf("t3_rdy_k%0d", k), DATA_W'(req_rdy), DATA_W'(e_rdy));
      chk($sformatf("t3_rsp_k%0d", k), DATA_W'(rsp_vld), (k == 11) ? DATA_W'(4'b0001) : '0);
      tick();
    end

    // reset mid-operation discards tags; later result is an orphan
    do_reset();
    pkt_vld_out = 1'b1;
    tick();
    pkt_vld_out = 1'b0;
    #1 chk("t5_rsp_vld", DATA_W'(rsp_vld), '0);
    chk("t5_orphan", DATA_W'(err_orphan), DATA_W'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_orphan_sticky%0d", k), DATA_W'(err_orphan), DATA_W'(1));
    end
    do_reset();
    #1 chk("t5_orphan_cleared", DATA_W'(err_orphan), '0);

    // requesters 1 and 3 valid; stage returns each packet right away
    do_reset();
    req_vld = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      pkt_vld_out = (k % 2 == 1);
      #1;
`ifdef STATEFULL_ARB_STRICT_PRIO_EN
      e_rdy = (k % 2 == 0) ? 4'b0010 : 4'b0000;
`else
      e_rdy = (k % 2 == 0) ? ((k % 4 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
`endif
      chk($sformatf("t6_rdy_k%0d", k), DATA_W'(req_rdy), DATA_W'(e_rdy));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
